// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, the full-word byte
// select and the default parameter values.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemBusy = 2'd1,
    StIfBusy  = 2'd2
  } arb_state_e;

  // Instruction fetches always read the whole word.
  localparam logic [3:0] SelFull = 4'b1111;

  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefTimeoutCycles = 255;

endpackage

// File: rtl/arb_timeout.sv
// Bus watchdog for the arbiter. Counts BUSY cycles that pass without an ack and
// fires a one-cycle timeout when the TIMEOUT_CYCLES-th such cycle is reached. The
// error flag is sticky until reset. Compiled only when ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   busy_i     - arbiter is in a BUSY state (transfer outstanding)
//   ack_i      - bus acknowledge
//   timeout_o  - this cycle is the last one the transfer may wait
//   err_o      - sticky timeout flag
`ifdef ARB_TIMEOUT_EN
module arb_timeout
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic ack_i,
  output logic timeout_o,
  output logic err_o
);

  // At least 8 bits, wider only if the limit needs it.
  localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            waiting;

  assign waiting   = busy_i & ~ack_i;
  assign timeout_o = waiting & (cnt_q == CntLast);

  always_comb begin
    cnt_d = '0;
    if (waiting && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | timeout_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one bus between the instruction-fetch (IF) and memory
// (MEM) pipeline stages. MEM has priority. The winner's request is registered onto
// the bus and held until ack; read data is captured into a per-side register and a
// per-side done flag suppresses re-issue until that side's hold input drops.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   if_*                          - IF request, hold, read data, stall request
//   mem_*                         - MEM request, hold, read data, stall request
//   bus_*                         - shared bus master interface
//   bus_err_o                     - sticky watchdog error (ARB_TIMEOUT_EN only)
//
// Configuration macro: ARB_TIMEOUT_EN enables the arb_timeout watchdog and bus_err_o.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic              clk,
  input  logic              rst,
  // IF side
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_hold_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              stallreq_if_o,
  // MEM side
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_hold_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_mem_o,
  // Shared bus
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  arb_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic              busy;
  logic              timeout;
  logic              xfer_end;
  logic [DATA_W-1:0] xfer_rdata;

  assign busy = (state_q != StIdle);

`ifdef ARB_TIMEOUT_EN
  arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_arb_timeout (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (busy),
    .ack_i    (bus_ack_i),
    .timeout_o(timeout),
    .err_o    (bus_err_o)
  );
`else
  assign timeout = 1'b0;
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  // A timed-out transfer completes like an ack but delivers zero data.
  assign xfer_end   = bus_ack_i | timeout;
  assign xfer_rdata = timeout ? '0 : bus_rdata_i;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // Done survives only while the stage stays frozen.
    if_done_d   = if_done_q & if_hold_i;
    mem_done_d  = mem_done_q & mem_hold_i;

    unique case (state_q)
      StIdle: begin
        if (mem_ce_i && !mem_done_q) begin
          state_d     = StMemBusy;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_ce_i && !if_done_q) begin
          state_d     = StIfBusy;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = SelFull;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end
      end
      StMemBusy: begin
        if (xfer_end) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          // A requester that has gone away gets no data and no done.
          if (mem_ce_i) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = xfer_rdata;
          end
        end
      end
      StIfBusy: begin
        if (xfer_end) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          if (if_ce_i) begin
            if_done_d  = 1'b1;
            if_rdata_d = xfer_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_sel_o      = bus_sel_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign stallreq_if_o  = ~rst & if_ce_i & ~if_done_q;
  assign stallreq_mem_o = ~rst & mem_ce_i & ~mem_done_q;

endmodule
